// File: rtl/axil_reg_bank.sv
// rtl/axil_reg_bank.sv - AXI4-Lite register bank with RW control and RO status registers
// Writes land in flops and pulse wr_pulse the cycle after execution; reads are registered.
module axil_reg_bank #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 8,
    parameter int NUM_RO             = 2,
    localparam int NUM_RW = NUM_REGS - NUM_RO,
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8,
    localparam int RO_W   = (NUM_RO > 0) ? NUM_RO * C_S_AXI_DATA_WIDTH : C_S_AXI_DATA_WIDTH
) (
    input  logic                               s00_axi_aclk,
    input  logic                               s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]      s00_axi_awaddr,
    input  logic [2:0]                         s00_axi_awprot,
    input  logic                               s00_axi_awvalid,
    output logic                               s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]      s00_axi_wdata,
    input  logic [STRB_W-1:0]                  s00_axi_wstrb,
    input  logic                               s00_axi_wvalid,
    output logic                               s00_axi_wready,
    output logic [1:0]                         s00_axi_bresp,
    output logic                               s00_axi_bvalid,
    input  logic                               s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]      s00_axi_araddr,
    input  logic [2:0]                         s00_axi_arprot,
    input  logic                               s00_axi_arvalid,
    output logic                               s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      s00_axi_rdata,
    output logic [1:0]                         s00_axi_rresp,
    output logic                               s00_axi_rvalid,
    input  logic                               s00_axi_rready,
    output logic [NUM_RW*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [RO_W-1:0]                    ro_in,
    output logic [NUM_RW-1:0]                  wr_pulse
);
    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic              ready_en_q, ready_en_d;
    logic              aw_full_q, aw_full_d;
    logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
    logic              w_full_q, w_full_d;
    logic [DW-1:0]     w_data_q, w_data_d;
    logic [STRB_W-1:0] w_strb_q, w_strb_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              rvalid_q, rvalid_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [DW-1:0]     regs_q [NUM_RW];
    logic [DW-1:0]     regs_d [NUM_RW];
    logic [NUM_RW-1:0] wr_pulse_q, wr_pulse_d;

    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_exec;
    logic [31:0] wr_idx, rd_idx;
    logic        unused_ok;

    // Readies stay low through reset and rise on the first edge after it.
    assign s00_axi_awready = ready_en_q & ~aw_full_q;
    assign s00_axi_wready  = ready_en_q & ~w_full_q;
    assign s00_axi_arready = ready_en_q & ~rvalid_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = rresp_q;
    assign wr_pulse        = wr_pulse_q;

    assign aw_hs   = s00_axi_awvalid & s00_axi_awready;
    assign w_hs    = s00_axi_wvalid & s00_axi_wready;
    assign b_hs    = bvalid_q & s00_axi_bready;
    assign ar_hs   = s00_axi_arvalid & s00_axi_arready;
    assign r_hs    = rvalid_q & s00_axi_rready;
    assign wr_exec = aw_full_q & w_full_q & ~bvalid_q;
    assign wr_idx  = 32'(aw_idx_q);
    assign rd_idx  = 32'(s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB]);

    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[ADDR_LSB-1:0], s00_axi_araddr[ADDR_LSB-1:0]};

    always_comb begin
        for (int i = 0; i < NUM_RW; i++) begin
            reg_out[i*DW +: DW] = regs_q[i];
        end
    end

    always_comb begin
        ready_en_d = 1'b1;
        aw_full_d  = aw_full_q;
        aw_idx_d   = aw_idx_q;
        w_full_d   = w_full_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;
        if (b_hs) begin
            bvalid_d = 1'b0;
        end
        if (wr_exec) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = RESP_SLVERR;
            if (wr_idx < 32'(NUM_RW)) begin
                bresp_d = RESP_OKAY;
                for (int i = 0; i < NUM_RW; i++) begin
                    if (wr_idx == 32'(i)) begin
                        for (int b = 0; b < STRB_W; b++) begin
                            if (w_strb_q[b]) begin
                                regs_d[i][8*b +: 8] = w_data_q[8*b +: 8];
                            end
                        end
                        wr_pulse_d[i] = |w_strb_q;
                    end
                end
            end
        end
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = s00_axi_wdata;
            w_strb_d = s00_axi_wstrb;
        end
    end

    // Reads sample regs_q before any same-cycle write lands, so they see the old value.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (r_hs) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_SLVERR;
            for (int i = 0; i < NUM_RW; i++) begin
                if (rd_idx == 32'(i)) begin
                    rdata_d = regs_q[i];
                    rresp_d = RESP_OKAY;
                end
            end
            for (int j = 0; j < NUM_RO; j++) begin
                if (rd_idx == 32'(NUM_RW + j)) begin
                    rdata_d = ro_in[j*DW +: DW];
                    rresp_d = RESP_OKAY;
                end
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
        if (s00_axi_areset) begin
            ready_en_q <= 1'b0;
            aw_full_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_RW; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            ready_en_q <= ready_en_d;
            aw_full_q  <= aw_full_d;
            aw_idx_q   <= aw_idx_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            wr_pulse_q <= wr_pulse_d;
            for (int i = 0; i < NUM_RW; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end
endmodule

// File: tb/tb_axil_reg_bank.sv
// tb/tb_axil_reg_bank.sv - directed table-driven bench for axil_reg_bank
// Address width widened to 7 so out-of-range index 0x40 is reachable.
module tb_axil_reg_bank;
    localparam int DW = 32;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic [191:0]  reg_out;
    logic [63:0]   ro_in;
    logic [5:0]    wr_pulse;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    axil_reg_bank #(.C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW),
                    .NUM_REGS(8), .NUM_RO(2)) dut (
        .s00_axi_aclk(clk), .s00_axi_areset(rst),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid),
        .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready),
        .reg_out(reg_out), .ro_in(ro_in), .wr_pulse(wr_pulse)
    );

    typedef struct {
        bit          wr;
        logic [6:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        logic [5:0]  exp_mask;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_delay, output logic [1:0] resp,
                             output logic [5:0] pmask, output int pcnt, output bit done);
        bit aw_sent, aw_h, w_h, b_h;
        int cyc;
        awaddr = a; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
        aw_sent = 1'b0; done = 1'b0; pmask = '0; pcnt = 0; resp = 2'b11; cyc = 0;
        while (!done && cyc < 100) begin
            if (!aw_sent && cyc >= aw_delay) awvalid = 1'b1;
            aw_h = awvalid && awready;
            w_h  = wvalid && wready;
            b_h  = bvalid && bready;
            if (bvalid) resp = bresp;
            if (wr_pulse != 0) begin
                pcnt++;
                pmask = pmask | wr_pulse;
            end
            tick();
            cyc++;
            if (aw_h) begin awvalid = 1'b0; aw_sent = 1'b1; end
            if (w_h) wvalid = 1'b0;
            if (b_h) begin bready = 1'b0; done = 1'b1; end
        end
        if (wr_pulse != 0) pcnt++;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    endtask

    task automatic axi_read(input logic [6:0] a, input int stall, output logic [31:0] d,
                            output logic [1:0] r, output int hs, output bit stable);
        bit ar_h, r_h, got;
        int seen, cyc;
        araddr = a; arvalid = 1'b1; rready = (stall == 0);
        hs = 0; stable = 1'b1; seen = 0; got = 1'b0; d = '0; r = 2'b11; cyc = 0;
        while (!got && cyc < 100) begin
            if (rvalid) begin
                if (seen > 0 && (rdata !== d || rresp !== r)) stable = 1'b0;
                d = rdata; r = rresp; seen++;
                if (seen > stall) rready = 1'b1;
            end
            ar_h = arvalid && arready;
            r_h  = rvalid && rready;
            tick();
            cyc++;
            if (ar_h) arvalid = 1'b0;
            if (r_h) begin hs++; got = 1'b1; rready = 1'b0; end
        end
        if (!got) hs = 0;
        arvalid = 1'b0; rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  resp;
        logic [5:0]  pmask;
        logic [31:0] d;
        int          pcnt, hs, cyc;
        bit          done, stable, bseen, rseen;

        rst = 1'b1; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        wdata = '0; wstrb = '0; ro_in = {32'hCAFEF00D, 32'h600D0006};

        vecs.push_back('{1'b1, 7'h00, 32'h1, 4'hF, 32'h0, 2'b00, 6'h01});
        vecs.push_back('{1'b1, 7'h04, 32'h2, 4'hF, 32'h0, 2'b00, 6'h02});
        vecs.push_back('{1'b1, 7'h08, 32'h3, 4'hF, 32'h0, 2'b00, 6'h04});
        vecs.push_back('{1'b1, 7'h0C, 32'h4, 4'hF, 32'h0, 2'b00, 6'h08});
        vecs.push_back('{1'b0, 7'h00, 32'h0, 4'h0, 32'h1, 2'b00, 6'h00});
        vecs.push_back('{1'b0, 7'h04, 32'h0, 4'h0, 32'h2, 2'b00, 6'h00});
        vecs.push_back('{1'b0, 7'h08, 32'h0, 4'h0, 32'h3, 2'b00, 6'h00});
        vecs.push_back('{1'b0, 7'h0C, 32'h0, 4'h0, 32'h4, 2'b00, 6'h00});
        vecs.push_back('{1'b1, 7'h18, 32'hDEADDEAD, 4'hF, 32'h0, 2'b10, 6'h00});
        vecs.push_back('{1'b1, 7'h40, 32'hBEEFBEEF, 4'hF, 32'h0, 2'b10, 6'h00});
        vecs.push_back('{1'b1, 7'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 2'b00, 6'h00});
        vecs.push_back('{1'b0, 7'h10, 32'h0, 4'h0, 32'h0, 2'b00, 6'h00});
        vecs.push_back('{1'b0, 7'h18, 32'h0, 4'h0, 32'h600D0006, 2'b00, 6'h00});
        vecs.push_back('{1'b0, 7'h1C, 32'h0, 4'h0, 32'hCAFEF00D, 2'b00, 6'h00});
        vecs.push_back('{1'b0, 7'h40, 32'h0, 4'h0, 32'h0, 2'b10, 6'h00});
        vecs.push_back('{1'b0, 7'h03, 32'h0, 4'h0, 32'h1, 2'b00, 6'h00});
        vecs.push_back('{1'b1, 7'h14, 32'h12345678, 4'h3, 32'h0, 2'b00, 6'h20});
        vecs.push_back('{1'b0, 7'h14, 32'h0, 4'h0, 32'h00005678, 2'b00, 6'h00});

        // reset state
        tick(); tick();
        chk("rst_readies", {awready, wready, arready}, 3'b000);
        chk("rst_valids", {bvalid, rvalid}, 2'b00);
        chk("rst_reg_out", reg_out, '0);
        chk("rst_misc", {wr_pulse, rdata, bresp, rresp}, '0);
        rst = 1'b0;
        #1;
        chk("ready_before_edge", {awready, wready, arready}, 3'b000);
        tick();
        chk("ready_first_edge", {awready, wready, arready}, 3'b111);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, resp, pmask, pcnt, done);
                chk($sformatf("v%0d_wr_done", i), done, 1'b1);
                chk($sformatf("v%0d_bresp", i), resp, vecs[i].exp_resp);
                chk($sformatf("v%0d_pulse_mask", i), pmask, vecs[i].exp_mask);
                chk($sformatf("v%0d_pulse_cnt", i), pcnt, (vecs[i].exp_mask != 0) ? 1 : 0);
            end else begin
                axi_read(vecs[i].addr, 0, d, resp, hs, stable);
                chk($sformatf("v%0d_rd_hs", i), hs, 1);
                chk($sformatf("v%0d_rdata", i), d, vecs[i].exp_data);
                chk($sformatf("v%0d_rresp", i), resp, vecs[i].exp_resp);
            end
        end
        chk("table_reg_out", reg_out,
            {32'h00005678, 32'h0, 32'h4, 32'h3, 32'h2, 32'h1});

        // W leads AW by three cycles, partial strobes
        axi_write(7'h08, 32'h11223344, 4'hF, 0, resp, pmask, pcnt, done);
        axi_write(7'h08, 32'hAABBCCDD, 4'b0101, 3, resp, pmask, pcnt, done);
        chk("wfirst_done", done, 1'b1);
        chk("wfirst_bresp", resp, 2'b00);
        chk("wfirst_pulse", {pmask, 8'(pcnt)}, {6'h04, 8'd1});
        axi_read(7'h08, 0, d, resp, hs, stable);
        chk("wfirst_rdata", d, 32'h11BB33DD);

        // RO read with rready stalled
        axi_read(7'h1C, 10, d, resp, hs, stable);
        chk("stall_rdata", d, 32'hCAFEF00D);
        chk("stall_stable", stable, 1'b1);
        chk("stall_hs", hs, 1);
        chk("stall_rvalid_after", rvalid, 1'b0);

        // same-cycle read and write of index 0
        axi_write(7'h00, 32'h5, 4'hF, 0, resp, pmask, pcnt, done);
        awaddr = 7'h00; wdata = 32'h9; wstrb = 4'hF; araddr = 7'h00;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        chk("same_all_ready", {awready, wready, arready}, 3'b111);
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; rready = 1'b1; bready = 1'b1;
        bseen = 1'b0; rseen = 1'b0; d = '0;
        for (cyc = 0; cyc < 20 && !(bseen && rseen); cyc++) begin
            if (rvalid && !rseen) begin d = rdata; rseen = 1'b1; end
            if (bvalid) bseen = 1'b1;
            tick();
        end
        rready = 1'b0; bready = 1'b0;
        chk("same_handshakes", {bseen, rseen}, 2'b11);
        chk("same_old_rdata", d, 32'h5);
        axi_read(7'h00, 0, d, resp, hs, stable);
        chk("same_new_rdata", d, 32'h9);

        // reset between AW and W handshakes
        awaddr = 7'h04; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_regs", reg_out, '0);
        chk("midrst_readies", {awready, wready, arready, bvalid}, 4'b0000);
        tick(); tick();
        rst = 1'b0;
        bseen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bvalid) bseen = 1'b1;
        end
        chk("midrst_no_bvalid", bseen, 1'b0);
        chk("midrst_aw_free", {awready, wready}, 2'b11);
        axi_write(7'h04, 32'h77, 4'hF, 0, resp, pmask, pcnt, done);
        chk("post_rst_write", {7'(done), resp, pmask}, {7'd1, 2'b00, 6'h02});
        chk("post_rst_reg_out", reg_out, {32'h0, 32'h0, 32'h0, 32'h0, 32'h77, 32'h0});

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/axil_reg_bank.md
AXIL_REG_BANK -- requirements
Module: axil_reg_bank

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32; AXI data width, 32 or 64 only.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5; byte address width, at least clog2(NUM_REGS)+clog2(C_S_AXI_DATA_WIDTH/8).
REQ-003 SHALL have parameter NUM_REGS, default 8; total register count, 2..64.
REQ-004 SHALL have parameter NUM_RO, default 2; the top NUM_RO indices are read-only status registers, 0..NUM_REGS-1.
REQ-005 SHALL have port s00_axi_aclk, input, 1; the sole clock, all logic on the rising edge.
REQ-006 SHALL have port s00_axi_areset, input, 1; asynchronous, active-high reset.
REQ-007 SHALL have write-address ports: s00_axi_awaddr in [C_S_AXI_ADDR_WIDTH]; s00_axi_awprot in 3 (ignored); s00_axi_awvalid in 1; s00_axi_awready out 1.
REQ-008 SHALL have write-data ports: s00_axi_wdata in [C_S_AXI_DATA_WIDTH]; s00_axi_wstrb in [C_S_AXI_DATA_WIDTH/8]; s00_axi_wvalid in 1; s00_axi_wready out 1.
REQ-009 SHALL have write-response ports: s00_axi_bresp out 2; s00_axi_bvalid out 1; s00_axi_bready in 1.
REQ-010 SHALL have read-address ports: s00_axi_araddr in [C_S_AXI_ADDR_WIDTH]; s00_axi_arprot in 3 (ignored); s00_axi_arvalid in 1; s00_axi_arready out 1.
REQ-011 SHALL have read-data ports: s00_axi_rdata out [C_S_AXI_DATA_WIDTH]; s00_axi_rresp out 2; s00_axi_rvalid out 1; s00_axi_rready in 1.
REQ-012 SHALL have port reg_out, output, (NUM_REGS-NUM_RO)*C_S_AXI_DATA_WIDTH; flattened RW registers, index 0 in the LSBs.
REQ-013 SHALL have port ro_in, input, NUM_RO*C_S_AXI_DATA_WIDTH; live status values for the RO indices.
REQ-014 SHALL have port wr_pulse, output, NUM_REGS-NUM_RO; one-cycle strobe per RW register on update.

Function
REQ-015 SHALL decode register index = addr >> clog2(C_S_AXI_DATA_WIDTH/8); low byte-offset bits ignored.
REQ-016 SHALL accept AW and W independently, each into its own 1-deep holding register; awready/wready high iff the respective holding register is empty.
REQ-017 SHALL execute a write in the cycle both holding registers are full and bvalid is low; SHALL assert bvalid the next cycle and free both holding registers.
REQ-018 SHALL update only the byte lanes with wstrb=1; wstrb=0 gives a write with no data change, bresp OKAY and no wr_pulse.
REQ-019 SHALL assert wr_pulse[i] for exactly the cycle in which RW register i changes; the new value is visible on reg_out in the same cycle.
REQ-020 SHALL respond bresp=SLVERR (2'b10) with no state change for index >= NUM_REGS or an RO index; otherwise OKAY (2'b00).
REQ-021 SHALL hold bvalid and bresp until the bready handshake; a new write SHALL NOT execute while bvalid is high.
REQ-022 SHALL assert arready iff rvalid is low; on the AR handshake, rvalid SHALL rise next cycle with rdata registered.
REQ-023 SHALL return the RW value, or ro_in sampled at the AR handshake for RO indices; index >= NUM_REGS returns rdata=0 with rresp=SLVERR.
REQ-024 SHALL hold rdata/rresp/rvalid stable until the rready handshake; rready low for any duration SHALL stall with no loss.
REQ-025 SHALL return the pre-write value when a read and a write to the same register are accepted in the same cycle.
REQ-026 SHALL sustain one write per 2 cycles with bready tied high and one read per 2 cycles with rready tied high; read and write paths operate concurrently.

Reset
REQ-027 SHALL, while s00_axi_areset=1, clear all RW registers, holding registers, bvalid, rvalid, rdata, bresp, rresp, wr_pulse and all readies to 0.
REQ-028 SHALL raise awready, wready and arready on the first rising edge after reset deasserts.
REQ-029 SHALL discard any in-flight transaction on reset mid-operation; no bvalid or rvalid SHALL follow it.

Verification
REQ-030 SHALL cover, with defaults: write 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C -> bresp OKAY each, readback matches, wr_pulse[0..3] each high one cycle.
REQ-031 SHALL cover: W presented 3 cycles before AW at 0x08 with data 0xAABBCCDD, wstrb 4'b0101 over 0x11223344 -> reads 0x11BB33DD.
REQ-032 SHALL cover: write 0x18 (RO) and read 0x40 -> bresp SLVERR with register unchanged; rresp SLVERR with rdata 0.
REQ-033 SHALL cover: ro_in[63:32]=0xCAFEF00D, read 0x1C with rready held low 10 cycles -> rdata 0xCAFEF00D stable throughout, single handshake.
REQ-034 SHALL cover: same-cycle read and write of 0x00 (old 0x5, new 0x9) -> rdata 0x5, subsequent read 0x9.
REQ-035 SHALL cover: reset asserted between the AW and W handshakes -> no bvalid, reg_out all 0, next write completes normally.
